// File: rtl/fcmp_pkg.sv
// Shared types and binary32 field helpers for the FP compare scheduler.
package fcmp_pkg;

  typedef enum logic [1:0] {
    OP_LT  = 2'b00,
    OP_LE  = 2'b01,
    OP_EQ  = 2'b10,
    OP_RSV = 2'b11
  } fcmp_op_t;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[EXP_MSB:EXP_LSB] == 8'hFF) && (x[MAN_MSB:MAN_LSB] != 23'd0);
  endfunction

  function automatic logic is_subnorm(input logic [31:0] x);
    return (x[EXP_MSB:EXP_LSB] == 8'h00) && (x[MAN_MSB:MAN_LSB] != 23'd0);
  endfunction

  function automatic logic [31:0] flush_subnorm(input logic [31:0] x);
    return is_subnorm(x) ? {x[SIGN_BIT], 31'd0} : x;
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// LAT-stage binary32 comparator carrying a requester tag alongside the result.
// Build option: FCMP_SUBNORM_FLUSH_EN flushes subnormal operands to signed zero.
module fcmp_core
  import fcmp_pkg::*;
#(
  parameter int LAT = 1,
  parameter int TW  = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [31:0]   in_x1,
  input  logic [31:0]   in_x2,
  input  fcmp_op_t      in_op,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  output logic [TW-1:0] out_tag,
  output logic          out_y
);

  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        y_s;
  logic [LAT-1:0]         vld_r;
  logic [LAT-1:0]         y_r;
  logic [LAT-1:0][TW-1:0] tag_r;

  // Sign-magnitude is remapped to an unsigned ordering key; both zeros compare equal.
  function automatic logic fcmp_eval(input logic [31:0] a, input logic [31:0] b,
                                     input fcmp_op_t op);
    logic        both_zero;
    logic        eq;
    logic        lt;
    logic [31:0] ka;
    logic [31:0] kb;
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    ka = a[SIGN_BIT] ? ~a : (a | 32'h8000_0000);
    kb = b[SIGN_BIT] ? ~b : (b | 32'h8000_0000);
    eq = both_zero || (a == b);
    lt = !both_zero && (ka < kb);
    if (is_nan(a) || is_nan(b)) begin
      return 1'b0;
    end else begin
      case (op)
        OP_LT:   return lt;
        OP_LE:   return lt | eq;
        OP_EQ:   return eq;
        default: return 1'b0;
      endcase
    end
  endfunction

  // Operand conditioning and compare evaluation at pipeline entry.
  always_comb begin
`ifdef FCMP_SUBNORM_FLUSH_EN
    a_s = flush_subnorm(in_x1);
    b_s = flush_subnorm(in_x2);
`else
    a_s = in_x1;
    b_s = in_x2;
`endif
    y_s = fcmp_eval(a_s, b_s, in_op);
  end

  // Result/tag shift pipeline; reset drops everything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_r <= '0;
      y_r   <= '0;
      tag_r <= '0;
    end else begin
      vld_r[0] <= in_valid;
      y_r[0]   <= y_s;
      tag_r[0] <= in_tag;
      for (int s = 1; s < LAT; s++) begin
        vld_r[s] <= vld_r[s-1];
        y_r[s]   <= y_r[s-1];
        tag_r[s] <= tag_r[s-1];
      end
    end
  end

  assign out_valid = vld_r[LAT-1];
  assign out_y     = y_r[LAT-1];
  assign out_tag   = tag_r[LAT-1];

endmodule

// File: rtl/fcmp_sched.sv
// Round-robin scheduler sharing one pipelined FP compare unit among NREQ requesters.
// Build option: FCMP_SUBNORM_FLUSH_EN (handled inside fcmp_core).
module fcmp_sched
  import fcmp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_x1,
  input  logic [32*NREQ-1:0] req_x2,
  input  logic [2*NREQ-1:0] req_op,
  output logic [NREQ-1:0]   resp_valid,
  output logic [NREQ-1:0]   resp_y,
  input  logic [NREQ-1:0]   resp_ready
);

  localparam int TW = $clog2(NREQ);

  logic [NREQ-1:0] busy_r;
  logic [TW-1:0]   ptr_r;
  logic [NREQ-1:0] slot_v_r;
  logic [NREQ-1:0] slot_y_r;
  logic [NREQ-1:0] eligible_s;
  logic [NREQ-1:0] grant_s;
  logic [NREQ-1:0] take_s;
  logic [NREQ-1:0] wb_s;
  logic [TW-1:0]   gidx_s;
  logic            gvalid_s;
  logic [31:0]     x1_s;
  logic [31:0]     x2_s;
  logic [1:0]      op_s;
  logic            core_v_s;
  logic [TW-1:0]   core_tag_s;
  logic            core_y_s;

  assign eligible_s = req_valid & ~busy_r;
  assign take_s     = slot_v_r & resp_ready;
  assign req_ready  = grant_s;
  assign resp_valid = slot_v_r;
  assign resp_y     = slot_y_r;

  // Round-robin search from ptr, first eligible index wins; operands muxed by winner.
  always_comb begin
    int            idx_i;
    logic [TW-1:0] idx_s;
    logic          hit_s;
    logic          sel_s;
    gidx_s   = '0;
    gvalid_s = 1'b0;
    grant_s  = '0;
    x1_s     = 32'd0;
    x2_s     = 32'd0;
    op_s     = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx_i    = (int'(ptr_r) + k) % NREQ;
      idx_s    = idx_i[TW-1:0];
      hit_s    = !gvalid_s && eligible_s[idx_s];
      gidx_s   = hit_s ? idx_s : gidx_s;
      gvalid_s = gvalid_s | hit_s;
    end
    grant_s[gidx_s] = gvalid_s;
    for (int i = 0; i < NREQ; i++) begin
      sel_s = (gidx_s == TW'(i));
      x1_s  = x1_s | (req_x1[i*32 +: 32] & {32{sel_s}});
      x2_s  = x2_s | (req_x2[i*32 +: 32] & {32{sel_s}});
      op_s  = op_s | (req_op[i*2 +: 2] & {2{sel_s}});
    end
  end

  fcmp_core #(
    .LAT (LAT),
    .TW  (TW)
  ) u_core (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (gvalid_s),
    .in_x1     (x1_s),
    .in_x2     (x2_s),
    .in_op     (fcmp_op_t'(op_s)),
    .in_tag    (gidx_s),
    .out_valid (core_v_s),
    .out_tag   (core_tag_s),
    .out_y     (core_y_s)
  );

  // Decode pipeline exit into a one-hot slot write strobe.
  always_comb begin
    wb_s             = '0;
    wb_s[core_tag_s] = core_v_s;
  end

  // Outstanding-request bits and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_r <= '0;
      ptr_r  <= '0;
    end else begin
      busy_r <= (busy_r | grant_s) & ~take_s;
      if (gvalid_s) begin
        ptr_r <= (gidx_s == TW'(NREQ - 1)) ? '0 : gidx_s + 1'b1;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Response slots: written only at pipeline exit, so resp_y holds while valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_v_r <= '0;
      slot_y_r <= '0;
    end else begin
      slot_v_r <= (slot_v_r & ~take_s) | wb_s;
      slot_y_r <= (slot_y_r & ~wb_s) | (wb_s & {NREQ{core_y_s}});
    end
  end

endmodule

// File: tb/tb_fcmp_sched.sv
// Scoreboard bench for fcmp_sched: table-driven compare vectors, expected results
// queued at acceptance and checked (index, value, latency) when a slot fills.
module tb_fcmp_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int NVEC = 16;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_x1 = '0;
  logic [32*NREQ-1:0]  req_x2 = '0;
  logic [2*NREQ-1:0]   req_op = '0;
  logic [NREQ-1:0]     resp_valid;
  logic [NREQ-1:0]     resp_y;
  logic [NREQ-1:0]     resp_ready = '1;

  typedef struct { int idx; logic y; int due; } exp_t;
  exp_t sb_q[$];
  int   grant_log[$];

  logic [31:0] tbl_x1 [NVEC];
  logic [31:0] tbl_x2 [NVEC];
  logic [1:0]  tbl_op [NVEC];
  logic        tbl_y  [NVEC];
  int          vec_sel [NREQ];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  logic [NREQ-1:0] held = '0;

  fcmp_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x1     (req_x1),
    .req_x2     (req_x2),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tv(input int i, input logic [31:0] a, input logic [31:0] b,
                    input logic [1:0] op, input logic y);
    tbl_x1[i] = a; tbl_x2[i] = b; tbl_op[i] = op; tbl_y[i] = y;
  endtask

  // Monitor: score new slot fills, queue expectations for this edge's acceptances.
  always @(negedge clk) begin
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] take;
    logic [NREQ-1:0] nv;
    exp_t e;
    if (!rstn) begin
      held = '0;
    end else begin
      acc  = req_valid & req_ready;
      take = resp_valid & resp_ready;
      nv   = resp_valid & ~held;
      chk("ready_onehot", ($countones(req_ready) <= 1) ? 32'd1 : 32'd0, 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (nv[i]) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_resp", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            chk("resp_idx", i, e.idx);
            chk("resp_y", resp_y[i], e.y);
            chk("resp_latency", cyc, e.due);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          sb_q.push_back('{idx: i, y: tbl_y[vec_sel[i]], due: cyc + 1 + LAT});
          grant_log.push_back(i);
        end
      end
      held = resp_valid & ~take;
    end
  end

  task automatic set_req(input int i, input int v);
    vec_sel[i] = v;
    req_x1[32*i +: 32] = tbl_x1[v];
    req_x2[32*i +: 32] = tbl_x2[v];
    req_op[2*i +: 2]   = tbl_op[v];
    req_valid[i]       = 1'b1;
  endtask

  task automatic issue(input int i, input int v);
    logic ok;
    @(posedge clk); #1;
    set_req(i, v);
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1'b1;
    end
    chk("grant_wait", ok, 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) @(negedge clk);
    chk("drain", sb_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    req_valid = '0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_y", resp_y, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int gl0;
    int others;
    logic ok;
    logic y1;
    tv(0,  32'h3F800000, 32'h40000000, 2'b00, 1'b1);
    tv(1,  32'h3F800000, 32'h40000000, 2'b01, 1'b1);
    tv(2,  32'h3F800000, 32'h40000000, 2'b10, 1'b0);
    tv(3,  32'h80000000, 32'h00000000, 2'b10, 1'b1);
    tv(4,  32'h7FC00000, 32'h3F800000, 2'b00, 1'b0);
    tv(5,  32'hFF800000, 32'hC0000000, 2'b00, 1'b1);
    tv(6,  32'h40000000, 32'h3F800000, 2'b00, 1'b0);
    tv(7,  32'h3F800000, 32'h3F800000, 2'b01, 1'b1);
`ifdef FCMP_SUBNORM_FLUSH_EN
    tv(8,  32'h00000001, 32'h00000000, 2'b10, 1'b1);
    tv(9,  32'h00000000, 32'h00000001, 2'b00, 1'b0);
`else
    tv(8,  32'h00000001, 32'h00000000, 2'b10, 1'b0);
    tv(9,  32'h00000000, 32'h00000001, 2'b00, 1'b1);
`endif
    tv(10, 32'h3F800000, 32'h3F800000, 2'b11, 1'b0);
    tv(11, 32'hC0000000, 32'h3F800000, 2'b00, 1'b1);
    tv(12, 32'h80000000, 32'h00000000, 2'b00, 1'b0);
    tv(13, 32'h7F800000, 32'h7F800000, 2'b10, 1'b1);
    tv(14, 32'h7F800001, 32'h7F800001, 2'b10, 1'b0);
    tv(15, 32'hBF800000, 32'hC0000000, 2'b00, 1'b0);
    for (int i = 0; i < NREQ; i++) vec_sel[i] = 0;

    do_reset();
    @(negedge clk);
    chk("idle_req_ready", req_ready, 0);

    // single requests on requester 2: lt, le, eq
    for (int v = 0; v < 3; v++) begin
      issue(2, v);
      drain();
    end

    // round robin from a fresh pointer
    do_reset();
    grant_log.delete();
    @(posedge clk); #1;
    set_req(0, 3); set_req(1, 4); set_req(2, 5); set_req(3, 6);
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    chk("rr_count", (grant_log.size() >= 8) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (k < grant_log.size()) chk("rr_order", grant_log[k], k % NREQ);
    end
    drain();

    // backpressure on slot 1
    resp_ready = 4'b1101;
    @(posedge clk); #1;
    set_req(0, 11); set_req(1, 7); set_req(2, 13); set_req(3, 5);
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (resp_valid[1]) ok = 1'b1;
    end
    chk("bp_wait", ok, 1);
    y1 = resp_y[1];
    chk("bp_y_first", y1, 1);
    gl0 = grant_log.size();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_ready1", req_ready[1], 0);
      chk("bp_valid1", resp_valid[1], 1);
      chk("bp_y_stable", resp_y[1], y1);
    end
    others = grant_log.size() - gl0;
    chk("bp_others", (others >= 3) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    resp_ready = '1;
    drain();

    // subnormals and assorted edge vectors
    issue(0, 8);
    issue(1, 9);
    for (int v = 10; v < NVEC; v++) issue(v % NREQ, v);
    drain();

    // reset with two requests in flight
    gl0 = grant_log.size();
    @(posedge clk); #1;
    set_req(0, 0); set_req(1, 1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    req_valid = '0;
    sb_q.delete();
    chk("mf_inflight", grant_log.size() - gl0, 2);
    repeat (2) @(negedge clk);
    chk("mf_rst_valid", resp_valid, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      chk("mf_no_stale", resp_valid, 0);
    end
    issue(3, 5);
    drain();
    chk("final_queue", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fcmp_sched.md
# fcmp_sched

Round-robin scheduler that shares one pipelined FP compare unit (lt/le/eq on binary32) among NREQ requesters in the FPU. It arbitrates per-requester valid/ready requests, tracks in-flight tags through the compare pipeline, and holds each result in a per-requester response slot until it is consumed. It sits between the issue logic of the integer/FP pipelines and the comparator datapath.

## Interface
- NREQ, 4: number of requesters, 2..8
- LAT, 1: compare pipeline depth in cycles, 1..4
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request i presents operands
- req_ready  out  NREQ  grant; accept on req_valid[i] & req_ready[i] at a rising edge
- req_x1  in  32*NREQ  operand 1 of requester i, bits [32i+31:32i]
- req_x2  in  32*NREQ  operand 2 of requester i
- req_op  in  2*NREQ  00 lt (x1<x2), 01 le, 10 eq, 11 reserved
- resp_valid  out  NREQ  result slot i holds a result
- resp_y  out  NREQ  compare result of slot i
- resp_ready  in  NREQ  consumer takes slot i on resp_valid[i] & resp_ready[i]

## Operation
- busy[i] set on acceptance of requester i; cleared on the edge where resp_valid[i] & resp_ready[i]. One outstanding request per requester.
- Eligible i: req_valid[i] & !busy[i]. req_ready is combinational from req_valid, busy and ptr; at most one bit high per cycle; none when nothing is eligible.
- Round-robin: search starts at ptr, wraps at NREQ-1 -> 0; first eligible index granted. After a grant to g, ptr <= (g+1) mod NREQ; no grant leaves ptr unchanged.
- A requester consuming its response in cycle t cannot be granted until cycle t+1 (busy is registered).
- Accepted operands, op and tag (index) enter the compare pipeline; at exit, result written to slot[tag], resp_valid[tag] set.
- Semantics: +0 equals -0; any NaN operand gives 0 for all ops; ±inf compared by ordering; op 11 gives 0 but completes normally.
- resp_y is stable while resp_valid is high; slot cannot be overwritten while busy.
- Reset (any time, including mid-flight): in-flight entries discarded, busy, resp_valid and ptr cleared.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_y 0, ptr 0.
- Accepting edge E -> resp_valid[i] high after edge E+LAT; throughput one acceptance per cycle across requesters.
- resp_valid[i] falls after the edge where it is consumed; held indefinitely otherwise, no deadline.
- Simultaneous: compare-pipeline writeback to slot j and consumption of slot k (j != k) in the same cycle are independent; j == k cannot occur.

## Configuration
- FCMP_SUBNORM_FLUSH_EN defined: subnormal inputs (exp 0, mantissa != 0) flushed to zero of the same sign before comparison, so 0x00000001 eq 0x00000000 -> 1.
- Undefined: subnormals compared exactly; 0x00000001 eq 0x00000000 -> 0, 0x00000000 lt 0x00000001 -> 1.

## Structure
- Shared package fcmp_pkg: fcmp_op_t enum (OP_LT, OP_LE, OP_EQ, OP_RSV), constants for binary32 field positions, NaN/subnormal classify functions.
- One sub-module fcmp_core: LAT-stage comparator carrying a tag alongside operands; fcmp_sched holds arbiter, busy bits, ptr and response slots.

## Test plan
- Single request: NREQ=4, LAT=1, req 2 with x1=0x3F800000, x2=0x40000000, op lt at edge E -> resp_valid[2] after E+1, resp_y=1; le -> 1; eq -> 0.
- All four valid continuously, resp_ready all 1 -> grants 0,1,2,3,0 on successive eligible cycles; ptr wraps to 0.
- Zeros/NaN: 0x80000000 eq 0x00000000 -> 1; 0x7FC00000 lt 0x3F800000 -> 0; 0xFF800000 lt 0xC0000000 -> 1.
- Backpressure: resp_ready[1]=0 for 10 cycles -> req_ready[1] stays 0, resp_y[1] stable; others still granted.
- Subnormal: 0x00000001 eq 0x00000000 -> 1 with FCMP_SUBNORM_FLUSH_EN, 0 without.
- Reset with LAT=3 and two requests in flight -> resp_valid all 0 after reset release, no stale result appears later.
